// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Desc     : Shared constants and FSM state type for the register bank
//            access controller.
// Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int RF_ADDR_WIDTH = 4;
    localparam int RF_WIDTH      = 32;
    localparam int RF_READ_LAT   = 2;
    localparam int RF_WRITE_LAT  = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        W1    = 3'd2,
        CAP   = 3'd3,
        VALID = 3'd4
    } rf_acc_state_t;

endpackage
`default_nettype wire

// File: rtl/rf_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : rf_fwd_unit
// Desc     : Per-operand writeback forwarding: override register, address
//            compare and capture-cycle operand selection.
// Revision : 1.0 - initial release
// ============================================================================
module rf_fwd_unit
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int WIDTH      = RF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  arm,
    input  logic                  wb_fire,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [WIDTH-1:0]      dout,
    output logic                  hit,
    output logic [WIDTH-1:0]      sel_data
);

    logic             r_ovr_vld;
    logic [WIDTH-1:0] r_ovr_data;
    logic             w_hit;

    assign w_hit = wb_fire && (wb_addr == src_addr);

    // Writes landing while the bank read is in flight are invisible to it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_vld  <= 1'b0;
            r_ovr_data <= '0;
        end else if (clr) begin
            r_ovr_vld  <= 1'b0;
        end else if (arm && w_hit) begin
            r_ovr_vld  <= 1'b1;
            r_ovr_data <= wb_data;
        end
    end

    always_comb begin
        sel_data = dout;
        if (w_hit) begin
            sel_data = wb_data;
        end else if (r_ovr_vld) begin
            sel_data = r_ovr_data;
        end
    end

    assign hit = w_hit;

endmodule
`default_nettype wire

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_ctrl
// Desc     : Operand-fetch initiator for the register bank; absorbs the
//            two-edge read latency and drives the bank write port.
// Config   : REGFILE_BYPASS_EN enables writeback forwarding into operands.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int WIDTH      = RF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_rs1,
    input  logic [ADDR_WIDTH-1:0] req_rs2,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [WIDTH-1:0]      op_a,
    output logic [WIDTH-1:0]      op_b,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic                  read_port_1,
    output logic                  read_port_2,
    output logic [ADDR_WIDTH-1:0] addr_port_1,
    output logic [ADDR_WIDTH-1:0] addr_port_2,
    output logic                  write_port,
    output logic [ADDR_WIDTH-1:0] addr_port_write,
    output logic [WIDTH-1:0]      din_port_write,
    input  logic [WIDTH-1:0]      dout_port_1,
    input  logic [WIDTH-1:0]      dout_port_2
);

    rf_acc_state_t         r_state;
    rf_acc_state_t         w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_rs1;
    logic [ADDR_WIDTH-1:0] r_rs2;
    logic [WIDTH-1:0]      r_op_a;
    logic [WIDTH-1:0]      r_op_b;

    logic                  w_req_ready;
    logic                  w_wb_ready;
    logic                  w_rd_en;
    logic                  w_op_valid;
    logic                  w_stall;
    logic                  w_idle_ok;
    logic                  w_req_fire;
    logic                  w_wb_fire;
    logic                  w_hit_a;
    logic                  w_hit_b;
    logic [WIDTH-1:0]      w_cap_a;
    logic [WIDTH-1:0]      w_cap_b;

`ifdef REGFILE_BYPASS_EN
    localparam logic c_BYPASS = 1'b1;

    logic w_fwd_arm;

    assign w_idle_ok = 1'b1;
    assign w_fwd_arm = (r_state == RD) || (r_state == W1);

    rf_fwd_unit #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (WIDTH)
    ) u_fwd_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_req_fire),
        .arm      (w_fwd_arm),
        .wb_fire  (w_wb_fire),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .src_addr (r_rs1),
        .dout     (dout_port_1),
        .hit      (w_hit_a),
        .sel_data (w_cap_a)
    );

    rf_fwd_unit #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (WIDTH)
    ) u_fwd_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_req_fire),
        .arm      (w_fwd_arm),
        .wb_fire  (w_wb_fire),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .src_addr (r_rs2),
        .dout     (dout_port_2),
        .hit      (w_hit_b),
        .sel_data (w_cap_b)
    );
`else
    localparam logic c_BYPASS = 1'b0;

    logic r_wb_block;

    // Hold off a fetch for one cycle so the bank has committed the last write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_block <= 1'b0;
        end else begin
            r_wb_block <= w_wb_fire;
        end
    end

    assign w_idle_ok = ~r_wb_block;
    assign w_hit_a   = 1'b0;
    assign w_hit_b   = 1'b0;
    assign w_cap_a   = dout_port_1;
    assign w_cap_b   = dout_port_2;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_rd_en     = 1'b0;
        w_op_valid  = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = w_idle_ok;
                if (req_valid && w_idle_ok) begin
                    w_state_nxt = RD;
                end
            end
            RD: begin
                w_rd_en     = 1'b1;
                w_stall     = 1'b1;
                w_state_nxt = W1;
            end
            W1: begin
                w_stall     = 1'b1;
                w_state_nxt = CAP;
            end
            CAP: begin
                w_stall     = 1'b1;
                w_state_nxt = VALID;
            end
            VALID: begin
                w_op_valid = 1'b1;
                if (op_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_wb_ready = c_BYPASS | ~w_stall;
    assign w_req_fire = req_valid & w_req_ready;
    assign w_wb_fire  = wb_valid & w_wb_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rs1   <= '0;
            r_rs2   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_fire) begin
                r_rs1 <= req_rs1;
                r_rs2 <= req_rs2;
            end
        end
    end

    // Operands are captured once from the bank; VALID only takes forwarded writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (r_state == CAP) begin
            r_op_a <= w_cap_a;
            r_op_b <= w_cap_b;
        end else if (r_state == VALID) begin
            if (w_hit_a) begin
                r_op_a <= wb_data;
            end
            if (w_hit_b) begin
                r_op_b <= wb_data;
            end
        end
    end

    assign req_ready       = w_req_ready;
    assign op_valid        = w_op_valid;
    assign op_a            = r_op_a;
    assign op_b            = r_op_b;
    assign wb_ready        = w_wb_ready;
    assign read_port_1     = w_rd_en;
    assign read_port_2     = w_rd_en;
    assign addr_port_1     = r_rs1;
    assign addr_port_2     = r_rs2;
    assign write_port      = w_wb_fire;
    assign addr_port_write = wb_addr;
    assign din_port_write  = wb_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_access_ctrl
// Desc     : Self-checking bench with a behavioural register bank and an
//            architectural register-file reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_access_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_rs1 = '0;
    logic [AW-1:0] req_rs2 = '0;
    logic          op_valid;
    logic          op_ready = 1'b0;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          read_port_1;
    logic          read_port_2;
    logic [AW-1:0] addr_port_1;
    logic [AW-1:0] addr_port_2;
    logic          write_port;
    logic [AW-1:0] addr_port_write;
    logic [DW-1:0] din_port_write;
    logic [DW-1:0] dout_port_1 = '0;
    logic [DW-1:0] dout_port_2 = '0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.ADDR_WIDTH(AW), .WIDTH(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rs1         (req_rs1),
        .req_rs2         (req_rs2),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_a            (op_a),
        .op_b            (op_b),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .read_port_1     (read_port_1),
        .read_port_2     (read_port_2),
        .addr_port_1     (addr_port_1),
        .addr_port_2     (addr_port_2),
        .write_port      (write_port),
        .addr_port_write (addr_port_write),
        .din_port_write  (din_port_write),
        .dout_port_1     (dout_port_1),
        .dout_port_2     (dout_port_2)
    );

    // Register bank: writes commit two edges after write_port, reads return
    // the array contents sampled on the second edge after read_port.
    logic [DW-1:0] bank [16] = '{default: '0};
    logic          bw_p = 1'b0;
    logic [AW-1:0] bw_a = '0;
    logic [DW-1:0] bw_d = '0;
    logic          br1_p = 1'b0;
    logic          br2_p = 1'b0;
    logic [AW-1:0] br1_a = '0;
    logic [AW-1:0] br2_a = '0;

    always @(posedge clk) begin
        bw_p  <= write_port;
        bw_a  <= addr_port_write;
        bw_d  <= din_port_write;
        if (bw_p) bank[bw_a] <= bw_d;
        br1_p <= read_port_1;
        br2_p <= read_port_2;
        br1_a <= addr_port_1;
        br2_a <= addr_port_2;
        if (br1_p) dout_port_1 <= bank[br1_a];
        if (br2_p) dout_port_2 <= bank[br2_a];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: one entry per accepted fetch; the reference register file
    // 'arch' holds every accepted writeback immediately.
    typedef struct {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        int            acc;
    } req_t;

    req_t          q[$];
    logic [DW-1:0] arch [16] = '{default: '0};
    logic          wb_prev = 1'b0;
    logic [DW-1:0] snap_a = '0;
    logic [DW-1:0] snap_b = '0;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    bit            busy;
    int            d;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            wb_prev = 1'b0;
            chk1("rst op_valid", op_valid, 1'b0);
            chk1("rst read_port_1", read_port_1, 1'b0);
            chk1("rst read_port_2", read_port_2, 1'b0);
            chk1("rst req_ready", req_ready, 1'b1);
            chk1("rst wb_ready", wb_ready, 1'b1);
            chkv("rst operands", 64'({op_a, op_b}), 64'd0);
            chkv("rst addr ports", 64'({addr_port_1, addr_port_2}), 64'd0);
        end else begin
            busy = (q.size() > 0);
            d    = busy ? (cyc - q[0].acc) : 0;
            chk1("req_ready", req_ready, !busy && (BYP || !wb_prev));
            chk1("wb_ready", wb_ready, BYP || !(busy && d >= 1 && d <= 3));
            chk1("write_port", write_port, wb_valid && (BYP || !(busy && d >= 1 && d <= 3)));
            if (write_port) begin
                chkv("write passthrough", 64'({addr_port_write, din_port_write}),
                     64'({wb_addr, wb_data}));
            end
            chk1("read_port_1", read_port_1, busy && d == 1);
            chk1("read_port_2", read_port_2, busy && d == 1);
            if (busy && (d == 1 || d == 2)) begin
                chkv("read addrs", 64'({addr_port_1, addr_port_2}), 64'({q[0].rs1, q[0].rs2}));
            end
            chk1("op_valid", op_valid, busy && d >= 4);
            if (busy && d >= 4 && op_valid) begin
                if (d == 4) begin
                    snap_a = arch[q[0].rs1];
                    snap_b = arch[q[0].rs2];
                end
                ea = BYP ? arch[q[0].rs1] : snap_a;
                eb = BYP ? arch[q[0].rs2] : snap_b;
                chkv("op_a", 64'(op_a), 64'(ea));
                chkv("op_b", 64'(op_b), 64'(eb));
                if (op_ready) void'(q.pop_front());
            end
            wb_prev = wb_valid && wb_ready;
            if (wb_valid && wb_ready) arch[wb_addr] = wb_data;
            if (req_valid && req_ready) q.push_back('{req_rs1, req_rs2, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wb(input int a, input logic [DW-1:0] v);
        wb_valid = 1'b1;
        wb_addr  = AW'(a);
        wb_data  = v;
        tick();
        wb_valid = 1'b0;
    endtask

    // Returns in the RD cycle of the accepted fetch
    task automatic send_req(input int a, input int b);
        req_valid = 1'b1;
        req_rs1   = AW'(a);
        req_rs2   = AW'(b);
        for (int g = 0; g < 50 && !req_ready; g++) tick();
        chk1("request accepted in time", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic take_op(input int hold);
        for (int g = 0; g < 50 && !op_valid; g++) tick();
        chk1("operands presented in time", op_valid, 1'b1);
        repeat (hold) tick();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // basic fetch
        wb(3, 32'h11);
        wb(5, 32'h22);
        repeat (3) tick();
        send_req(3, 5);
        take_op(0);

        // writeback during W1
        wb(7, 32'hAA);
        tick();
        send_req(7, 0);
        tick();
        wb(7, 32'hBB);
        take_op(0);

        // forward priority: RD write then CAP write, rs1 == rs2
        send_req(2, 2);
        wb(2, 32'h1);
        tick();
        wb(2, 32'h2);
        take_op(0);

        // writeback while operands are held in VALID
        wb(4, 32'h44);
        tick();
        send_req(4, 1);
        repeat (3) tick();
        wb(4, 32'h55);
        repeat (3) tick();
        take_op(0);

        // reset in the middle of a fetch
        send_req(3, 5);
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send_req(3, 5);
        take_op(1);

        // back-pressure and r0 as an ordinary register
        send_req(7, 4);
        take_op(10);
        wb(0, 32'hDEAD_BEEF);
        tick();
        send_req(0, 3);
        take_op(2);

        // randomised traffic concentrated on a few registers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_addr   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3))
                                                    : AW'($urandom_range(0, 15));
            wb_data   = $urandom;
            req_valid = 1'($urandom_range(0, 1));
            req_rs1   = AW'($urandom_range(0, 3));
            req_rs2   = AW'($urandom_range(0, 3));
            op_ready  = ($urandom_range(0, 2) != 0);
            tick();
        end

        wb_valid  = 1'b0;
        req_valid = 1'b0;
        op_ready  = 1'b1;
        repeat (10) tick();
        chkv("scoreboard drained", 64'(q.size()), 64'd0);
        op_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
